// File: rtl/led_pkg.sv
// Shared types and helpers for the led_breath LED driver.
package led_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    localparam int PWM_BITS_DEFAULT = 8;

    function automatic int max_of(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_breath_pwm_gen.sv
// PWM counter, step tick generation and registered two-channel compare.
// Compare is gamma-corrected when LED_BREATH_GAMMA_EN is defined.
module pwm_gen
    import led_pkg::*;
#(
    parameter int PWM_BITS         = PWM_BITS_DEFAULT,
    parameter int PERIODS_PER_STEP = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PWM_BITS-1:0] duty_a,
    input  logic [PWM_BITS-1:0] duty_b,
    output logic                step_tick,
    output logic [1:0]          led
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(max_of(PWM_BITS));
    localparam int PW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIODS_PER_STEP - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PW-1:0]       period_cnt;

    function automatic logic [PWM_BITS-1:0] compare_value(input logic [PWM_BITS-1:0] d);
`ifdef LED_BREATH_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
        return sq[2*PWM_BITS-1:PWM_BITS];
`else
        return d;
`endif
    endfunction

    // Full duty must be solid on, which a strict less-than compare alone cannot give.
    function automatic logic lit(input logic [PWM_BITS-1:0] d, input logic [PWM_BITS-1:0] cnt);
        return (d == MAX) || (cnt < compare_value(d));
    endfunction

    assign step_tick = en && (pwm_cnt == MAX) && (period_cnt == PERIOD_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours; blocking here would create ordering bugs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt    <= '0;
            period_cnt <= '0;
            led        <= 2'b00;
        end else if (!en) begin
            pwm_cnt    <= '0;
            period_cnt <= '0;
            led        <= 2'b00;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == MAX)
                period_cnt <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 1'b1;
            led[0] <= lit(duty_a, pwm_cnt);
            led[1] <= lit(duty_b, pwm_cnt);
        end
    end

endmodule

// File: rtl/led_breath.sv
// Breathing-LED driver: triangle-ramped PWM duty on led[0], complement on led[1].
// Optional gamma-corrected compare via LED_BREATH_GAMMA_EN.
module led_breath
    import led_pkg::*;
#(
    parameter int PWM_BITS         = PWM_BITS_DEFAULT,
    parameter int PERIODS_PER_STEP = 12,
    parameter int HOLD_STEPS       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic [1:0]          led,
    output logic [PWM_BITS-1:0] duty,
    output logic                cycle_done
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(max_of(PWM_BITS));
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] duty_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                done_d;
    logic                step_tick;

    pwm_gen #(
        .PWM_BITS         (PWM_BITS),
        .PERIODS_PER_STEP (PERIODS_PER_STEP)
    ) u_pwm (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .duty_a    (duty),
        .duty_b    (MAX - duty),
        .step_tick (step_tick),
        .led       (led)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            duty       <= '0;
            hold_q     <= '0;
            cycle_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty       <= duty_d;
            hold_q     <= hold_d;
            cycle_done <= done_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        duty_d  = duty;
        hold_d  = hold_q;
        done_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            duty_d  = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = UP;
                    duty_d  = '0;
                    hold_d  = '0;
                end
                UP: if (step_tick) begin
                    duty_d = (duty == MAX) ? MAX : duty + 1'b1;
                    if (duty_d == MAX) begin
                        hold_d  = '0;
                        state_d = (HOLD_STEPS == 0) ? DOWN : HOLD_HI;
                    end
                end
                HOLD_HI: if (step_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = DOWN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                DOWN: if (step_tick) begin
                    duty_d = (duty == '0) ? '0 : duty - 1'b1;
                    if (duty_d == '0) begin
                        hold_d = '0;
                        if (HOLD_STEPS == 0) begin
                            state_d = UP;
                            done_d  = 1'b1;
                        end else begin
                            state_d = HOLD_LO;
                        end
                    end
                end
                HOLD_LO: if (step_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = UP;
                        done_d  = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_breath.sv
// Randomized scoreboard bench for led_breath against a per-cycle arithmetic model.
module tb_led_breath;

    localparam int PWM_BITS   = 4;
    localparam int PPS        = 1;
    localparam int HOLD       = 2;
    localparam int MAXV       = (1 << PWM_BITS) - 1;
    localparam int TICK_CYC   = (MAXV + 1) * PPS;          // cycles per duty step
    localparam int BREATH     = 2 * MAXV + 2 * HOLD;       // step ticks per breath
    localparam int BREATH_CYC = BREATH * TICK_CYC;

    typedef struct packed {
        logic [1:0]          led;
        logic [PWM_BITS-1:0] duty;
        logic                done;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic [1:0]          led;
    logic [PWM_BITS-1:0] duty;
    logic                cycle_done;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   t_model = -1;   // index of the last enabled cycle sampled; -1 when idle

    led_breath #(
        .PWM_BITS         (PWM_BITS),
        .PERIODS_PER_STEP (PPS),
        .HOLD_STEPS       (HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .led        (led),
        .duty       (duty),
        .cycle_done (cycle_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Triangle profile as a function of step ticks since enable.
    function automatic int ref_duty(input int n);
        int p;
        p = n % BREATH;
        if (p <= MAXV)                return p;
        else if (p <= MAXV + HOLD)    return MAXV;
        else if (p <= 2*MAXV + HOLD)  return 2*MAXV + HOLD - p;
        else                          return 0;
    endfunction

    function automatic int eff(input int d);
`ifdef LED_BREATH_GAMMA_EN
        return (d * d) >> PWM_BITS;
`else
        return d;
`endif
    endfunction

    function automatic logic ref_lit(input int d, input int cnt);
        return (d == MAXV) || (cnt < eff(d));
    endfunction

    // Expected outputs after the coming edge, given en sampled at that edge.
    task automatic model_push(input logic e);
        exp_t x;
        int   c, d, cnt;
        x = '0;
        if (!e) begin
            t_model = -1;
        end else begin
            c   = t_model + 1;
            d   = ref_duty(c / TICK_CYC);
            cnt = c % (MAXV + 1);
            x.led[0] = ref_lit(d, cnt);
            x.led[1] = ref_lit(MAXV - d, cnt);
            x.duty   = PWM_BITS'(ref_duty((c + 1) / TICK_CYC));
            x.done   = ((c + 1) % BREATH_CYC) == 0;
            t_model  = c;
        end
        sb.push_back(x);
    endtask

    task automatic step(input logic e);
        @(negedge clk);
        en = e;
        model_push(e);
    endtask

    // Monitor: one registered output set per clock, checked mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                check("led",        led,        x.led);
                check("duty",       duty,       x.duty);
                check("cycle_done", cycle_done, x.done);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d entries pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_led",  led,        0);
        check("reset_duty", duty,       0);
        check("reset_done", cycle_done, 0);
        rst_n = 1'b1;

        repeat (20) step(1'b0);

        // Two full breaths; ends at duty 7 mid-ramp.
        repeat (1200) step(1'b1);
        repeat (3) step(1'b0);
        repeat (100) step(1'b1);

        for (int s = 0; s < 30; s++) begin
            repeat ($urandom_range(1, 4)) step(1'b0);
            repeat ($urandom_range(1, 700)) step(1'b1);
        end

        // Asynchronous reset while in HOLD_HI.
        repeat (3) step(1'b0);
        repeat (16 * TICK_CYC + 8) step(1'b1);
        @(posedge clk);
        #4;
        check("hold_hi_duty", duty, MAXV);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("async_led",  led,        0);
        check("async_duty", duty,       0);
        check("async_done", cycle_done, 0);
        t_model = -1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step(1'b0);
        repeat (100) step(1'b1);

        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
